// File: rtl/trend_event_fifo.sv
// -----------------------------------------------------------------------------
// trend_event_fifo
//
// Watches a qualified trend bit, detects level changes and queues each change
// as an event {new_level, timestamp} in a small FIFO for a downstream consumer.
// The timestamp is a free-running count of qualified samples. Events that
// arrive while the FIFO is full (and nothing is leaving that cycle) are
// dropped and flagged by a sticky overflow bit; a saturating counter tallies
// every detected transition, dropped or not.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   TS_WIDTH  timestamp counter width
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   trend_in    trend bit from the upstream stage
//   sample_en   qualifies trend_in; nothing is sampled when low
//   clear       synchronous flush of FIFO, counters and overflow flag
//   evt_ready   consumer accepts the head event
//   evt_valid   head event present
//   evt_data    {level, timestamp} of the head event (zero when empty)
//   evt_count   detected transitions, saturating at 255
//   overflow    sticky: an event was dropped
//   fifo_level  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module trend_event_fifo #(
  parameter int DEPTH    = 4,
  parameter int TS_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         trend_in,
  input  logic                         sample_en,
  input  logic                         clear,
  input  logic                         evt_ready,
  output logic                         evt_valid,
  output logic [TS_WIDTH:0]            evt_data,
  output logic [7:0]                   evt_count,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                LVL_W    = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);

  logic [TS_WIDTH:0]    mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [LVL_W-1:0]     level;
  logic                 prev_trend;
  logic [TS_WIDTH-1:0]  ts;
  logic [7:0]           count;
  logic                 ovf;

  logic detect;
  logic full;
  logic pop;
  logic accept;
  logic drop;

  assign detect = sample_en && (trend_in != prev_trend);
  assign full   = (level == FULL_LVL);
  assign pop    = evt_valid && evt_ready;
  // A full FIFO can still take a new event when the head leaves the same cycle.
  assign accept = detect && (!full || pop);
  assign drop   = detect && full && !pop;

  assign evt_valid  = (level != '0);
  // Masking with evt_valid gives a defined zero after reset even though the
  // storage array itself is never reset.
  assign evt_data   = evt_valid ? mem[rd_ptr] : '0;
  assign evt_count  = count;
  assign overflow   = ovf;
  assign fifo_level = level;

  // NOTE: all state registers use non-blocking assignments so every flop in
  // this block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      prev_trend <= 1'b0;
      ts         <= '0;
      count      <= '0;
      ovf        <= 1'b0;
    end else begin
      // prev_trend follows the sampled input even on a clear cycle, so the
      // level seen during a flush is not reported again afterwards.
      if (sample_en) prev_trend <= trend_in;

      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
        ts     <= '0;
        count  <= '0;
        ovf    <= 1'b0;
      end else begin
        if (sample_en) ts     <= ts + TS_WIDTH'(1);
        if (accept)    wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);

        // NOTE: the explicit default keeps the hold case visible; in a
        // combinational case the same default is what prevents a latch.
        case ({accept, pop})
          2'b10:   level <= level + LVL_W'(1);
          2'b01:   level <= level - LVL_W'(1);
          default: level <= level;
        endcase

        if (detect && (count != 8'hFF)) count <= count + 8'd1;
        if (drop)                       ovf   <= 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by level and
  // the pointers, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (accept && !clear) mem[wr_ptr] <= {trend_in, ts};
  end

endmodule
